unidade_controle_jogo: RTL and testbench

Moore-type controller that sequences the memory-game datapath (address counter, round counter, play register, sequence RAM, comparator) through reset, replay of the stored sequence, entry of a new play, and the win/loss/timeout endings. It also contains the per-play inactivity timer. It sits beside the datapath inside `circuito_jogo_base` and drives every datapath control strobe plus the `ganhou`/`perdeu`/`pronto` game outputs.

---
 rtl/jogo_pkg.sv | 29 ++
 rtl/unidade_controle_jogo_contador_timeout.sv | 45 ++++
 rtl/unidade_controle_jogo.sv | 152 +++++++++++++++
 tb/tb_unidade_controle_jogo.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// -----------------------------------------------------------------------------
// jogo_pkg
// Shared definitions for the memory-game control unit:
//   - estado_t             : 4-bit state codes (visible on db_estado)
//   - TIMEOUT_CICLOS_PADRAO: default clock cycles allowed per play
// -----------------------------------------------------------------------------
package jogo_pkg;

    localparam int TIMEOUT_CICLOS_PADRAO = 5000;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARA        = 4'h1,
        INICIO_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARA        = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PREP_NOVA      = 4'h7,
        ESPERA_NOVA    = 4'h8,
        REGISTRA_NOVA  = 4'h9,
        ESCREVE        = 4'hA,
        PROXIMA_RODADA = 4'hB,
        FIM_ACERTO     = 4'hC,
        FIM_ERRO       = 4'hD,
        FIM_TIMEOUT    = 4'hE
    } estado_t;

endpackage

// File: rtl/unidade_controle_jogo_contador_timeout.sv
// -----------------------------------------------------------------------------
// contador_timeout
// Per-play inactivity timer with saturating count and registered terminal flag.
// Ports:
//   i_clock   : clock, rising edge
//   i_reset_n : asynchronous reset, active low
//   i_clear   : synchronous clear of count and flag
//   i_enable  : count one per cycle (saturates at MODULO-1)
//   o_fim     : registered flag, high the cycle after the count sits at MODULO-1
// -----------------------------------------------------------------------------
module contador_timeout #(
    parameter int MODULO = 5000
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_fim
);

    localparam int W = (MODULO > 1) ? $clog2(MODULO) : 1;
    localparam logic [W-1:0] MAXIMO = W'(MODULO - 1);

    logic [W-1:0] r_conta;
    logic         r_fim;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_conta <= '0;
            r_fim   <= 1'b0;
        end else if (i_clear) begin
            r_conta <= '0;
            r_fim   <= 1'b0;
        end else begin
            if (i_enable && (r_conta != MAXIMO))
                r_conta <= r_conta + 1'b1;
            // Flag follows the count one cycle later; it stays high while the
            // count is saturated so the final state keeps showing the expiry.
            r_fim <= (r_conta == MAXIMO);
        end
    end

    assign o_fim = r_fim;

endmodule

// File: rtl/unidade_controle_jogo.sv
// -----------------------------------------------------------------------------
// unidade_controle_jogo
// Moore controller for the memory-game datapath: replays the stored sequence,
// takes a new play each round and ends in win / loss / timeout.
// Optional feature: define JOGO_TIMEOUT_EN to instantiate the inactivity timer;
// without it the wait states block indefinitely and db_timeout is 0.
// Ports:
//   clock, reset (async, active low)
//   jogar, jogada, igual, fimE, fimR          : status / requests
//   zeraE, contaE, zeraR, contaR, registraR,
//   escreveM                                  : datapath strobes
//   ganhou, perdeu, pronto                    : game results
//   db_estado, db_timeout                     : debug
// -----------------------------------------------------------------------------
module unidade_controle_jogo
    import jogo_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimE,
    input  logic       fimR,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraR,
    output logic       contaR,
    output logic       registraR,
    output logic       escreveM,
    output logic       ganhou,
    output logic       perdeu,
    output logic       pronto,
    output logic [3:0] db_estado,
    output logic       db_timeout
);

    estado_t r_estado;
    estado_t w_estado_next;
    logic    w_timeout;

`ifdef JOGO_TIMEOUT_EN
    logic w_timer_clr;
    logic w_timer_en;

    assign w_timer_clr = (r_estado == PREPARA) || (r_estado == INICIO_RODADA) ||
                         (r_estado == REGISTRA) || (r_estado == PREP_NOVA);
    assign w_timer_en  = (r_estado == ESPERA_JOGADA) || (r_estado == ESPERA_NOVA);

    contador_timeout #(
        .MODULO (TIMEOUT_CICLOS)
    ) u_timer (
        .i_clock   (clock),
        .i_reset_n (reset),
        .i_clear   (w_timer_clr),
        .i_enable  (w_timer_en),
        .o_fim     (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_estado <= INICIAL;
        else
            r_estado <= w_estado_next;
    end

    always_comb begin
        w_estado_next = r_estado;
        case (r_estado)
            INICIAL:        if (jogar) w_estado_next = PREPARA;
            PREPARA:        w_estado_next = INICIO_RODADA;
            INICIO_RODADA:  w_estado_next = ESPERA_JOGADA;
            // A captured play takes priority over a simultaneous expiry.
            ESPERA_JOGADA: begin
                if (jogada)         w_estado_next = REGISTRA;
                else if (w_timeout) w_estado_next = FIM_TIMEOUT;
            end
            REGISTRA:       w_estado_next = COMPARA;
            COMPARA: begin
                if (!igual)     w_estado_next = FIM_ERRO;
                else if (!fimE) w_estado_next = PROXIMA_JOGADA;
                else if (fimR)  w_estado_next = FIM_ACERTO;
                else            w_estado_next = PREP_NOVA;
            end
            PROXIMA_JOGADA: w_estado_next = ESPERA_JOGADA;
            PREP_NOVA:      w_estado_next = ESPERA_NOVA;
            ESPERA_NOVA: begin
                if (jogada)         w_estado_next = REGISTRA_NOVA;
                else if (w_timeout) w_estado_next = FIM_TIMEOUT;
            end
            REGISTRA_NOVA:  w_estado_next = ESCREVE;
            ESCREVE:        w_estado_next = PROXIMA_RODADA;
            PROXIMA_RODADA: w_estado_next = INICIO_RODADA;
            FIM_ACERTO,
            FIM_ERRO:       if (jogar) w_estado_next = PREPARA;
`ifdef JOGO_TIMEOUT_EN
            FIM_TIMEOUT:    if (jogar) w_estado_next = PREPARA;
`endif
            default:        w_estado_next = INICIAL;
        endcase
    end

    // Output decode depends on the registered state only.
    always_comb begin
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraR     = 1'b0;
        contaR    = 1'b0;
        registraR = 1'b0;
        escreveM  = 1'b0;
        ganhou    = 1'b0;
        perdeu    = 1'b0;
        pronto    = 1'b0;
        case (r_estado)
            PREPARA: begin
                zeraE = 1'b1;
                zeraR = 1'b1;
            end
            INICIO_RODADA:  zeraE     = 1'b1;
            REGISTRA:       registraR = 1'b1;
            PROXIMA_JOGADA: contaE    = 1'b1;
            PREP_NOVA:      contaE    = 1'b1;
            REGISTRA_NOVA:  registraR = 1'b1;
            ESCREVE:        escreveM  = 1'b1;
            PROXIMA_RODADA: contaR    = 1'b1;
            FIM_ACERTO: begin
                ganhou = 1'b1;
                pronto = 1'b1;
            end
            FIM_ERRO: begin
                perdeu = 1'b1;
                pronto = 1'b1;
            end
`ifdef JOGO_TIMEOUT_EN
            FIM_TIMEOUT: begin
                perdeu = 1'b1;
                pronto = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign db_estado  = r_estado;
    assign db_timeout = w_timeout;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
module tb_unidade_controle_jogo;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       jogar = 1'b0, jogada = 1'b0, igual = 1'b0, fimE = 1'b0, fimR = 1'b0;
    logic       zeraE, contaE, zeraR, contaR, registraR, escreveM;
    logic       ganhou, perdeu, pronto, db_timeout;
    logic [3:0] db_estado;

    int n_tests = 0;
    int n_fail  = 0;

    // Output bundle order: zeraE contaE zeraR contaR registraR escreveM ganhou perdeu pronto
    localparam logic [8:0] O_NONE = 9'b000000000;
    localparam logic [8:0] O_PREP = 9'b101000000;
    localparam logic [8:0] O_INIR = 9'b100000000;
    localparam logic [8:0] O_REG  = 9'b000010000;
    localparam logic [8:0] O_CONE = 9'b010000000;
    localparam logic [8:0] O_ESC  = 9'b000001000;
    localparam logic [8:0] O_CONR = 9'b000100000;
    localparam logic [8:0] O_WIN  = 9'b000000101;
    localparam logic [8:0] O_LOSE = 9'b000000011;

    unidade_controle_jogo #(.TIMEOUT_CICLOS(20)) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .jogada(jogada),
        .igual(igual), .fimE(fimE), .fimR(fimR),
        .zeraE(zeraE), .contaE(contaE), .zeraR(zeraR), .contaR(contaR),
        .registraR(registraR), .escreveM(escreveM),
        .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto),
        .db_estado(db_estado), .db_timeout(db_timeout)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [3:0] est, input logic [8:0] outs);
        $display("[TB] %s: estado=%0h outs=%b timeout=%b", tag, db_estado,
                 {zeraE, contaE, zeraR, contaR, registraR, escreveM, ganhou, perdeu, pronto},
                 db_timeout);
        chk({tag, ".estado"}, 32'(db_estado), 32'(est));
        chk({tag, ".saidas"}, 32'({zeraE, contaE, zeraR, contaR, registraR, escreveM,
                                   ganhou, perdeu, pronto}), 32'(outs));
    endtask

    initial begin
        // Reset state
        step(); step();
        chk_st("reset", 4'h0, O_NONE);
        chk("reset.timeout", 32'(db_timeout), 32'd0);
        reset = 1'b1;

        // Start and a round that grows the sequence
        jogar = 1'b1; step(); chk_st("prepara", 4'h1, O_PREP);
        jogar = 1'b0; step(); chk_st("inicio_rodada", 4'h2, O_INIR);
        step(); chk_st("espera_jogada", 4'h3, O_NONE);
        jogada = 1'b1; igual = 1'b1; fimE = 1'b1; fimR = 1'b0;
        step(); chk_st("registra", 4'h4, O_REG);
        jogada = 1'b0; step(); chk_st("compara", 4'h5, O_NONE);
        step(); chk_st("prep_nova", 4'h7, O_CONE);
        step(); chk_st("espera_nova", 4'h8, O_NONE);
        jogada = 1'b1; step(); chk_st("registra_nova", 4'h9, O_REG);
        jogada = 1'b0; step(); chk_st("escreve", 4'hA, O_ESC);
        step(); chk_st("proxima_rodada", 4'hB, O_CONR);
        step(); chk_st("inicio_rodada2", 4'h2, O_INIR);

        // Wrong play ends in FIM_ERRO, then restart
        step(); chk_st("espera_erro", 4'h3, O_NONE);
        igual = 1'b0; jogada = 1'b1; step(); chk_st("registra_erro", 4'h4, O_REG);
        jogada = 1'b0; step(); chk_st("compara_erro", 4'h5, O_NONE);
        step(); chk_st("fim_erro", 4'hD, O_LOSE);
        jogar = 1'b1; step(); chk_st("restart_erro", 4'h1, O_PREP);
        jogar = 1'b0;

        // Win; jogar held in ESPERA_JOGADA is ignored
        step(); step(); chk_st("espera_win", 4'h3, O_NONE);
        jogar = 1'b1; step(); chk_st("jogar_ignorado", 4'h3, O_NONE);
        igual = 1'b1; fimE = 1'b1; fimR = 1'b1; jogada = 1'b1;
        step(); chk_st("registra_win", 4'h4, O_REG);
        jogada = 1'b0; jogar = 1'b0; step(); step();
        chk_st("fim_acerto", 4'hC, O_WIN);
        step(); chk_st("fim_acerto_hold", 4'hC, O_WIN);
        jogar = 1'b1; step(); chk_st("restart_win", 4'h1, O_PREP);
        jogar = 1'b0;

        // Timeout in ESPERA_NOVA
        fimR = 1'b0; step(); step(); jogada = 1'b1;
        step(); jogada = 1'b0; step(); step();
        chk_st("prep_nova_to", 4'h7, O_CONE);
        step(); chk_st("espera_nova_to", 4'h8, O_NONE);
`ifdef JOGO_TIMEOUT_EN
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 19) chk("timeout_low_e19", 32'(db_timeout), 32'd0);
        end
        chk_st("espera_nova_e20", 4'h8, O_NONE);
        chk("timeout_high_e20", 32'(db_timeout), 32'd1);
        step(); chk_st("fim_timeout", 4'hE, O_LOSE);
        chk("fim_timeout.flag", 32'(db_timeout), 32'd1);
`else
        for (int i = 1; i <= 100; i++) step();
        chk_st("espera_nova_100", 4'h8, O_NONE);
        chk("no_timeout", 32'(db_timeout), 32'd0);
`endif
        // Asynchronous reset, checked before any clock edge
        #2 reset = 1'b0; #1;
        chk_st("async_reset1", 4'h0, O_NONE);
        chk("async_reset1.timeout", 32'(db_timeout), 32'd0);
        reset = 1'b1;

        // Simultaneous jogada and expiry in ESPERA_JOGADA
        jogar = 1'b1; step(); jogar = 1'b0; step(); step();
        chk_st("espera_sim", 4'h3, O_NONE);
        for (int i = 1; i <= 20; i++) step();
`ifdef JOGO_TIMEOUT_EN
        chk("sim.timeout", 32'(db_timeout), 32'd1);
`endif
        jogada = 1'b1; step(); chk_st("sim_registra", 4'h4, O_REG);
        jogada = 1'b0; igual = 1'b1; fimE = 1'b0;
        step(); step(); chk_st("proxima_jogada", 4'h6, O_CONE);

        // Reset in state 6 aborts immediately
        #2 reset = 1'b0; #1;
        chk_st("async_reset6", 4'h0, O_NONE);
        step(); chk_st("reset_held", 4'h0, O_NONE);
        reset = 1'b1; step(); chk_st("idle_after_reset", 4'h0, O_NONE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
